// File: rtl/add_sub_serial.sv
// Digit-serial two's-complement adder/subtractor, DIGIT bits per clock, LSB first.
// Optional: define ADD_SUB_SERIAL_SATURATE_EN to saturate Sum on signed overflow.
module add_sub_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             opSel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Overflow,
    output logic             CarryOut
);

    localparam int DG = (DIGIT < 1) ? 1 : DIGIT;
    localparam int N  = WIDTH / DG;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    generate
        if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH) begin : g_bad_range
            $error("add_sub_serial: illegal WIDTH/DIGIT");
        end else if (WIDTH % DIGIT != 0) begin : g_bad_div
            $error("add_sub_serial: DIGIT must divide WIDTH");
        end
    endgenerate

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             ovf_q, ovf_d;
    logic             co_q, co_d;
    logic             done_q, done_d;

    logic [DG:0]         dfull;
    logic [DG-1:0]       dsum;
    logic                dcout;
    logic                cin_msb;
    logic [WIDTH+DG-1:0] cat;
    logic [WIDTH-1:0]    res_nx;
    logic                ovf_nx;

    always_comb begin
        dfull = {1'b0, a_q[DG-1:0]} + {1'b0, b_q[DG-1:0]}
              + {{DG{1'b0}}, carry_q};
        dsum    = dfull[DG-1:0];
        dcout   = dfull[DG];
        // Carry into the top bit of this digit, recovered from its sum bit.
        cin_msb = a_q[DG-1] ^ b_q[DG-1] ^ dsum[DG-1];
        cat     = {dsum, res_q};
        res_nx  = cat[WIDTH+DG-1:DG];
        ovf_nx  = cin_msb ^ dcout;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        co_d    = co_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = opA;
                    b_d     = opB ^ {WIDTH{opSel}};
                    carry_d = opSel;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> DG;
                b_d     = b_q >> DG;
                res_d   = res_nx;
                carry_d = dcout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    sum_d   = res_nx;
`ifdef ADD_SUB_SERIAL_SATURATE_EN
                    if (ovf_nx) begin
                        sum_d = res_nx[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                                : {1'b1, {(WIDTH-1){1'b0}}};
                    end
`endif
                    ovf_d   = ovf_nx;
                    co_d    = dcout;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            co_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            co_q    <= co_d;
            done_q  <= done_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = done_q;
    assign Sum      = sum_q;
    assign Overflow = ovf_q;
    assign CarryOut = co_q;

endmodule

// File: tb/tb_add_sub_serial.sv
// Directed bench for add_sub_serial at DIGIT = 4, 1 and 16 (WIDTH = 16).
// Honours ADD_SUB_SERIAL_SATURATE_EN for the overflow vectors.
module tb_add_sub_serial;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] opA;
    logic [15:0] opB;
    logic        opSel;

    logic        busy_w [3];
    logic        done_w [3];
    logic [15:0] sum_w  [3];
    logic        ovf_w  [3];
    logic        co_w   [3];

    localparam int NL [3] = '{4, 16, 1};

`ifdef ADD_SUB_SERIAL_SATURATE_EN
    localparam logic [15:0] E_POS = 16'h7FFF;
    localparam logic [15:0] E_NEG = 16'h8000;
    localparam logic [15:0] E_MIN = 16'h8000;
`else
    localparam logic [15:0] E_POS = 16'h8000;
    localparam logic [15:0] E_NEG = 16'h7FFF;
    localparam logic [15:0] E_MIN = 16'h0000;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    add_sub_serial #(.WIDTH(16), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .opA(opA), .opB(opB), .opSel(opSel),
        .busy(busy_w[0]), .done(done_w[0]), .Sum(sum_w[0]),
        .Overflow(ovf_w[0]), .CarryOut(co_w[0])
    );

    add_sub_serial #(.WIDTH(16), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .opA(opA), .opB(opB), .opSel(opSel),
        .busy(busy_w[1]), .done(done_w[1]), .Sum(sum_w[1]),
        .Overflow(ovf_w[1]), .CarryOut(co_w[1])
    );

    add_sub_serial #(.WIDTH(16), .DIGIT(16)) u_d16 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .opA(opA), .opB(opB), .opSel(opSel),
        .busy(busy_w[2]), .done(done_w[2]), .Sum(sum_w[2]),
        .Overflow(ovf_w[2]), .CarryOut(co_w[2])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic launch(input logic [15:0] a, input logic [15:0] b,
                          input logic sel);
        opA   = a;
        opB   = b;
        opSel = sel;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int d, input int c0, output int c);
        c = c0;
        while (done_w[d] !== 1'b1 && c < 64) begin
            tick();
            c++;
        end
    endtask

    task automatic check_res(input int d, input string tag, input int c,
                             input logic [15:0] es, input logic eo,
                             input logic ec);
        chk({tag, "/lat"}, c, NL[d]);
        chk({tag, "/sum"}, sum_w[d], es);
        chk({tag, "/ovf"}, ovf_w[d], eo);
        chk({tag, "/co"}, co_w[d], ec);
        chk({tag, "/busy"}, busy_w[d], 1'b0);
    endtask

    task automatic do_op(input int d, input string tag,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic sel, input logic [15:0] es,
                         input logic eo, input logic ec);
        int c;
        launch(a, b, sel);
        chk({tag, "/busy1"}, busy_w[d], 1'b1);
        wait_done(d, 0, c);
        check_res(d, tag, c, es, eo, ec);
        tick();
        chk({tag, "/pulse"}, done_w[d], 1'b0);
    endtask

    initial begin
        int c;
        int pulses;
        rst_n = 1'b0;
        start = 1'b1;
        opA   = 16'hFFFF;
        opB   = 16'hFFFF;
        opSel = 1'b1;
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst%0d/busy", d), busy_w[d], 1'b0);
            chk($sformatf("rst%0d/done", d), done_w[d], 1'b0);
            chk($sformatf("rst%0d/sum", d), sum_w[d], 16'h0000);
            chk($sformatf("rst%0d/ovf", d), ovf_w[d], 1'b0);
            chk($sformatf("rst%0d/co", d), co_w[d], 1'b0);
        end
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("rst/nostart", busy_w[0], 1'b0);

        for (int d = 0; d < 3; d++) begin
            do_reset();
            do_op(d, $sformatf("add%0d", d),
                  16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
            do_op(d, $sformatf("sub57_%0d", d),
                  16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
            do_op(d, $sformatf("sub75_%0d", d),
                  16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b0, 1'b1);
            do_op(d, $sformatf("ovfp%0d", d),
                  16'h7FFF, 16'h0001, 1'b0, E_POS, 1'b1, 1'b0);
            do_op(d, $sformatf("ovfn%0d", d),
                  16'h8000, 16'h0001, 1'b1, E_NEG, 1'b1, 1'b1);
            do_op(d, $sformatf("wrap%0d", d),
                  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1);
            do_op(d, $sformatf("min%0d", d),
                  16'h8000, 16'h8000, 1'b0, E_MIN, 1'b1, 1'b1);
            do_op(d, $sformatf("pre%0d", d),
                  16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b0, 1'b1);

            if (NL[d] >= 3) begin
                launch(16'h1234, 16'h0FFF, 1'b0);
                tick();
                start = 1'b1;
                opA   = 16'hFFFF;
                opB   = 16'h0000;
                opSel = 1'b1;
                tick();
                start = 1'b0;
                chk($sformatf("ign%0d/busy", d), busy_w[d], 1'b1);
                chk($sformatf("ign%0d/hold", d), sum_w[d], 16'h0002);
                wait_done(d, 2, c);
                check_res(d, $sformatf("ign%0d", d), c,
                          16'h2233, 1'b0, 1'b0);
                tick();
            end

            launch(16'h0005, 16'h0007, 1'b1);
            wait_done(d, 0, c);
            check_res(d, $sformatf("b2b%0d_a", d), c, 16'hFFFE, 1'b0, 1'b0);
            launch(16'h7FFF, 16'h0001, 1'b0);
            wait_done(d, 0, c);
            check_res(d, $sformatf("b2b%0d_b", d), c, E_POS, 1'b1, 1'b0);
            tick();

            if (NL[d] >= 3) begin
                launch(16'h1234, 16'h0FFF, 1'b0);
                tick();
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
                chk($sformatf("mrst%0d/busy", d), busy_w[d], 1'b0);
                chk($sformatf("mrst%0d/done", d), done_w[d], 1'b0);
                chk($sformatf("mrst%0d/sum", d), sum_w[d], 16'h0000);
                chk($sformatf("mrst%0d/ovf", d), ovf_w[d], 1'b0);
                pulses = 0;
                for (int i = 0; i < NL[d] + 2; i++) begin
                    tick();
                    if (done_w[d] === 1'b1) pulses++;
                end
                chk($sformatf("mrst%0d/nodone", d), pulses, 0);
                do_op(d, $sformatf("after%0d", d),
                      16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
